// File: rtl/drygascon128_ctrl.sv
// Command sequencer for the drygascon128 permutation core.
// Streams C/X/I words into the core, launches G, waits for the core to go
// idle, then streams R (or C) words back out one word per handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command; cmd_ready follows core_idle
// LOAD_C  | taking 10 input words into C
// LOAD_X  | taking 4 input words into X
// ABSORB  | taking 4 input words as I for an F command
// START   | one-cycle core_start pulse
// WAIT    | first cycle blind, then wait for core_idle
// RD_REQ  | one-cycle core_rd_r / core_rd_c request
// RD_HOLD | capture core_dout, hold out_valid until out_ready
module drygascon128_ctrl #(
   parameter int ROUNDS = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [3:0]  cmd_ds,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic [31:0] core_din,
   output logic [3:0]  core_ds,
   output logic [3:0]  core_rounds,
   output logic        core_wr_c,
   output logic        core_wr_x,
   output logic        core_wr_i,
   output logic        core_start,
   output logic        core_rd_c,
   output logic        core_rd_r,
   input  logic [31:0] core_dout,
   input  logic        core_idle
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD_C  = 3'd1;
   localparam logic [2:0] ST_LOAD_X  = 3'd2;
   localparam logic [2:0] ST_ABSORB  = 3'd3;
   localparam logic [2:0] ST_START   = 3'd4;
   localparam logic [2:0] ST_WAIT    = 3'd5;
   localparam logic [2:0] ST_RD_REQ  = 3'd6;
   localparam logic [2:0] ST_RD_HOLD = 3'd7;

   localparam logic [1:0] OP_LOAD_CX = 2'd0;
   localparam logic [1:0] OP_F       = 2'd1;
   localparam logic [1:0] OP_G       = 2'd2;
   localparam logic [1:0] OP_READ_C  = 2'd3;

   localparam logic [3:0] ROUNDS_W = 4'(ROUNDS);

   logic [2:0]  state;
   logic [3:0]  wcnt;
   logic [1:0]  op_q;
   logic [3:0]  ds_q;
   logic [3:0]  rounds_q;

   logic        live;
   logic        load_state;
   logic        cmd_fire;
   logic        in_fire;
   logic        rd_req;
   logic        rd_last;

   // Handshakes are only offered in cycles that can actually advance the FSM,
   // so an upstream never sees a transfer that the controller then drops.
   assign live       = clk_en & ~rst;
   assign load_state = (state == ST_LOAD_C) | (state == ST_LOAD_X) | (state == ST_ABSORB);
   assign cmd_ready  = live & (state == ST_IDLE) & core_idle;
   assign in_ready   = live & load_state;
   assign cmd_fire   = cmd_valid & cmd_ready;
   assign in_fire    = in_valid & in_ready;

   assign core_din    = in_data;
   assign core_ds     = ds_q;
   assign core_rounds = rounds_q;

   // Every strobe is decoded from a distinct state, so at most one is ever high.
   assign core_wr_c  = in_fire & (state == ST_LOAD_C);
   assign core_wr_x  = in_fire & (state == ST_LOAD_X);
   assign core_wr_i  = in_fire & (state == ST_ABSORB);
   assign core_start = live & (state == ST_START);
   assign rd_req     = live & (state == ST_RD_REQ);
   assign core_rd_c  = rd_req & (op_q == OP_READ_C);
   assign core_rd_r  = rd_req & (op_q != OP_READ_C);

   assign rd_last = (op_q == OP_READ_C) ? (wcnt == 4'd9) : (wcnt == 4'd3);

   // Sequencer: command decode, word counting and output register.
   always_ff @(posedge clk) begin
      if (clk_en) begin
         if (rst) begin
            state     <= ST_IDLE;
            wcnt      <= 4'd0;
            op_q      <= OP_LOAD_CX;
            ds_q      <= 4'd0;
            rounds_q  <= 4'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 32'd0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cmd_fire) begin
                     op_q     <= cmd_op;
                     ds_q     <= cmd_ds;
                     rounds_q <= ROUNDS_W;
                     wcnt     <= 4'd0;
                     case (cmd_op)
                        OP_LOAD_CX: state <= ST_LOAD_C;
                        OP_F:       state <= ST_ABSORB;
                        OP_G:       state <= ST_START;
                        default:    state <= ST_RD_REQ;
                     endcase
                  end
               end
               ST_LOAD_C: begin
                  if (in_fire) begin
                     if (wcnt == 4'd9) begin
                        wcnt  <= 4'd0;
                        state <= ST_LOAD_X;
                     end else begin
                        wcnt <= wcnt + 4'd1;
                     end
                  end
               end
               ST_LOAD_X: begin
                  if (in_fire) begin
                     if (wcnt == 4'd3) begin
                        wcnt  <= 4'd0;
                        state <= ST_IDLE;
                     end else begin
                        wcnt <= wcnt + 4'd1;
                     end
                  end
               end
               ST_ABSORB: begin
                  if (in_fire) begin
                     if (wcnt == 4'd3) begin
                        wcnt  <= 4'd0;
                        state <= ST_START;
                     end else begin
                        wcnt <= wcnt + 4'd1;
                     end
                  end
               end
               ST_START: begin
                  state <= ST_WAIT;
               end
               ST_WAIT: begin
                  // wcnt doubles as the "first WAIT cycle seen" flag; core_idle
                  // may still show the pre-start value in that cycle.
                  if (wcnt == 4'd0) begin
                     wcnt <= 4'd1;
                  end else if (core_idle) begin
                     wcnt  <= 4'd0;
                     state <= ST_RD_REQ;
                  end
               end
               ST_RD_REQ: begin
                  state <= ST_RD_HOLD;
               end
               ST_RD_HOLD: begin
                  if (!out_valid) begin
                     out_data  <= core_dout;
                     out_valid <= 1'b1;
                     out_last  <= rd_last;
                  end else if (out_ready) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     if (rd_last) begin
                        wcnt  <= 4'd0;
                        state <= ST_IDLE;
                     end else begin
                        wcnt  <= wcnt + 4'd1;
                        state <= ST_RD_REQ;
                     end
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_drygascon128_ctrl.sv
// Directed bench for drygascon128_ctrl with a small behavioural core stub.
// Stub R word i = I[i] ^ X[i] ^ {ds, rounds, 24'h0}, latched at core_start.
module tb_drygascon128_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic        en_toggle = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [3:0]  cmd_ds = 4'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_last;
   logic [31:0] core_din;
   logic [3:0]  core_ds;
   logic [3:0]  core_rounds;
   logic        core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_c, core_rd_r;
   logic [31:0] core_dout;
   logic        core_idle;
   logic        force_busy = 1'b0;

   drygascon128_ctrl #(.ROUNDS(11)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ds(cmd_ds),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .core_din(core_din), .core_ds(core_ds), .core_rounds(core_rounds),
      .core_wr_c(core_wr_c), .core_wr_x(core_wr_x), .core_wr_i(core_wr_i),
      .core_start(core_start), .core_rd_c(core_rd_c), .core_rd_r(core_rd_r),
      .core_dout(core_dout), .core_idle(core_idle)
   );

   initial forever #5 clk = ~clk;

   always @(negedge clk) clk_en = en_toggle ? ~clk_en : 1'b1;

   // ---------------- core stub ----------------
   logic [31:0] c_mem [10];
   logic [31:0] x_mem [4];
   logic [31:0] i_mem [4];
   logic [31:0] r_mem [4];
   logic [3:0]  cp, xp, ip, rp, busy;
   logic        stub_idle;

   assign core_idle = stub_idle & ~force_busy;

   always @(posedge clk) begin
      if (clk_en) begin
         if (rst) begin
            cp <= 4'd0; xp <= 4'd0; ip <= 4'd0; rp <= 4'd0;
            busy <= 4'd0; stub_idle <= 1'b1; core_dout <= 32'd0;
         end else begin
            if (core_wr_c) begin c_mem[cp] <= core_din; cp <= (cp == 4'd9) ? 4'd0 : cp + 4'd1; end
            if (core_wr_x) begin x_mem[xp] <= core_din; xp <= (xp == 4'd3) ? 4'd0 : xp + 4'd1; end
            if (core_wr_i) begin i_mem[ip] <= core_din; ip <= (ip == 4'd3) ? 4'd0 : ip + 4'd1; end
            if (core_start) begin
               for (int i = 0; i < 4; i++)
                  r_mem[i] <= i_mem[i] ^ x_mem[i] ^ {core_ds, core_rounds, 24'h0};
               busy <= 4'd6;
               stub_idle <= 1'b0;
            end else if (busy != 4'd0) begin
               busy <= busy - 4'd1;
               if (busy == 4'd1) stub_idle <= 1'b1;
            end
            if (core_rd_c) begin core_dout <= c_mem[rp]; rp <= (rp == 4'd9) ? 4'd0 : rp + 4'd1; end
            if (core_rd_r) begin core_dout <= r_mem[rp]; rp <= (rp == 4'd3) ? 4'd0 : rp + 4'd1; end
         end
      end
   end

   // ---------------- strobe counters and rule monitor ----------------
   int n_wr_c = 0, n_wr_x = 0, n_wr_i = 0, n_start = 0, n_rd_c = 0, n_rd_r = 0;
   int viol = 0;

   always @(posedge clk) begin
      if (core_wr_c)  n_wr_c  <= n_wr_c + 1;
      if (core_wr_x)  n_wr_x  <= n_wr_x + 1;
      if (core_wr_i)  n_wr_i  <= n_wr_i + 1;
      if (core_start) n_start <= n_start + 1;
      if (core_rd_c)  n_rd_c  <= n_rd_c + 1;
      if (core_rd_r)  n_rd_r  <= n_rd_r + 1;
      if ($countones({core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_c, core_rd_r}) > 1 ||
          (!clk_en && {core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_c, core_rd_r} != 6'b0))
         viol <= viol + 1;
   end

   // ---------------- bench state ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] got_data [10];
   logic        got_last [10];
   logic [31:0] exp_f [4] = '{32'h4A11111B, 32'h79222229, 32'h6833333F, 32'h1F444449};
   logic [31:0] exp_g [4] = '{32'h2A11111B, 32'h19222229, 32'h0833333F, 32'h7F444449};
   logic [31:0] i_words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [3:0] ds, output int stalls, output bit to);
      cmd_valid = 1'b1; cmd_op = op; cmd_ds = ds;
      stalls = 0; to = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if (cmd_ready) begin to = 1'b0; step(); break; end
         step(); stalls++;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, output int stalls, output bit to);
      in_valid = 1'b1; in_data = d;
      stalls = 0; to = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if (in_ready) begin to = 1'b0; step(); break; end
         step(); stalls++;
      end
   endtask

   task automatic recv(input int n, output bit to);
      bit got;
      to = 1'b0;
      for (int k = 0; k < n; k++) begin
         got = 1'b0;
         for (int c = 0; c < 300; c++) begin
            if (out_valid && out_ready && clk_en) begin
               got_data[k] = out_data; got_last[k] = out_last; got = 1'b1;
               step(); break;
            end
            step();
         end
         if (!got) begin to = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step(); step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
      n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b want 0", out_last); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      n_cmp++; if (core_ds !== 4'd0 || core_rounds !== 4'd0) begin n_bad++; $display("FAIL reset_ds_rounds got %h/%h want 0/0", core_ds, core_rounds); end
      n_cmp++; if ({core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_c, core_rd_r} !== 6'b0) begin
         n_bad++; $display("FAIL reset_strobes got %b want 000000", {core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_c, core_rd_r}); end
      force_busy = 1'b1;
      rst = 1'b0;
      step();
      n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready_busy got %b want 0", cmd_ready); end
      force_busy = 1'b0;
      #1;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready_idle got %b want 1", cmd_ready); end
   endtask

   task automatic test_load_read();
      int st, tot, c0, x0, rc0, ov;
      bit to, any_to;
      c0 = n_wr_c; x0 = n_wr_x; rc0 = n_rd_c; tot = 0; any_to = 0; ov = 0;
      send_cmd(2'd0, 4'd0, st, to); any_to |= to;
      for (int k = 0; k < 14; k++) begin
         send_word(32'(k), st, to);
         tot += st; any_to |= to;
         if (out_valid) ov++;
      end
      in_valid = 1'b0;
      step(); step();
      n_cmp++; if (any_to) begin n_bad++; $display("FAIL load_timeout got timeout want handshakes"); end
      n_cmp++; if (n_wr_c - c0 != 10 || n_wr_x - x0 != 4) begin
         n_bad++; $display("FAIL load_strobes got wr_c=%0d wr_x=%0d want 10/4", n_wr_c - c0, n_wr_x - x0); end
      n_cmp++; if (tot != 0) begin n_bad++; $display("FAIL load_throughput got %0d stalls want 0", tot); end
      n_cmp++; if (ov != 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL load_no_output got %0d valid cycles want 0", ov); end
      send_cmd(2'd3, 4'd0, st, to);
      recv(10, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL readc_timeout got timeout want 10 words"); end
      for (int k = 0; k < 10; k++) begin
         n_cmp++; if (got_data[k] !== 32'(k) || got_last[k] !== (k == 9)) begin
            n_bad++; $display("FAIL readc_word%0d got %h last=%b want %h last=%b", k, got_data[k], got_last[k], k, (k == 9)); end
      end
      n_cmp++; if (n_rd_c - rc0 != 10) begin n_bad++; $display("FAIL readc_strobes got %0d want 10", n_rd_c - rc0); end
   endtask

   task automatic test_f(input bit toggle);
      int st, tot, i0, s0, r0, c0, x0, rc0;
      bit to, any_to;
      en_toggle = toggle;
      i0 = n_wr_i; s0 = n_start; r0 = n_rd_r; c0 = n_wr_c; x0 = n_wr_x; rc0 = n_rd_c;
      tot = 0; any_to = 0;
      send_cmd(2'd1, 4'h5, st, to); any_to |= to;
      for (int k = 0; k < 4; k++) begin
         send_word(i_words[k], st, to);
         tot += st; any_to |= to;
      end
      in_valid = 1'b0;
      recv(4, to); any_to |= to;
      en_toggle = 1'b0;
      step(); step();
      n_cmp++; if (any_to) begin n_bad++; $display("FAIL f%0d_timeout got timeout want completion", toggle); end
      n_cmp++; if (core_ds !== 4'h5 || core_rounds !== 4'd11) begin
         n_bad++; $display("FAIL f%0d_ds_rounds got %h/%0d want 5/11", toggle, core_ds, core_rounds); end
      if (!toggle) begin
         n_cmp++; if (tot != 0) begin n_bad++; $display("FAIL f_throughput got %0d stalls want 0", tot); end
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (got_data[k] !== exp_f[k] || got_last[k] !== (k == 3)) begin
            n_bad++; $display("FAIL f%0d_word%0d got %h last=%b want %h last=%b", toggle, k, got_data[k], got_last[k], exp_f[k], (k == 3)); end
      end
      n_cmp++; if (n_wr_i - i0 != 4 || n_start - s0 != 1 || n_rd_r - r0 != 4 ||
                   n_wr_c - c0 != 0 || n_wr_x - x0 != 0 || n_rd_c - rc0 != 0) begin
         n_bad++; $display("FAIL f%0d_strobes got wr_i=%0d start=%0d rd_r=%0d other=%0d want 4/1/4/0", toggle,
                           n_wr_i - i0, n_start - s0, n_rd_r - r0, (n_wr_c - c0) + (n_wr_x - x0) + (n_rd_c - rc0)); end
   endtask

   task automatic test_stall_g();
      int st, r0, r_all, bad_stable;
      bit to, seen;
      logic [31:0] d0;
      r_all = n_rd_r;
      out_ready = 1'b0;
      send_cmd(2'd2, 4'h3, st, to);
      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (out_valid) begin seen = 1'b1; break; end
         step();
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL stall_first_valid got timeout want out_valid"); end
      d0 = out_data; r0 = n_rd_r; bad_stable = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (out_valid !== 1'b1 || out_data !== d0) bad_stable++;
      end
      n_cmp++; if (bad_stable != 0) begin n_bad++; $display("FAIL stall_stable got %0d unstable cycles want 0", bad_stable); end
      n_cmp++; if (n_rd_r != r0) begin n_bad++; $display("FAIL stall_no_extra_rd got %0d extra want 0", n_rd_r - r0); end
      out_ready = 1'b1;
      recv(4, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL stall_timeout got timeout want 4 words"); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (got_data[k] !== exp_g[k] || got_last[k] !== (k == 3)) begin
            n_bad++; $display("FAIL g_word%0d got %h last=%b want %h last=%b", k, got_data[k], got_last[k], exp_g[k], (k == 3)); end
      end
      n_cmp++; if (n_rd_r - r_all != 4) begin n_bad++; $display("FAIL g_rd_r_count got %0d want 4", n_rd_r - r_all); end
   endtask

   task automatic test_reset_mid();
      int st, i0;
      bit to;
      i0 = n_wr_i;
      send_cmd(2'd1, 4'h5, st, to);
      send_word(i_words[0], st, to);
      send_word(i_words[1], st, to);
      in_data = i_words[2];
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      n_cmp++; if (n_wr_i - i0 != 2) begin n_bad++; $display("FAIL rstmid_wr_i got %0d want 2", n_wr_i - i0); end
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_outputs got valid=%b in_ready=%b want 0/0", out_valid, in_ready); end
      n_cmp++; if (cmd_ready !== 1'b1 || core_ds !== 4'd0) begin
         n_bad++; $display("FAIL rstmid_idle got cmd_ready=%b ds=%h want 1/0", cmd_ready, core_ds); end
      send_cmd(2'd3, 4'd0, st, to);
      recv(10, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL rstmid_readc_timeout got timeout want 10 words"); end
      for (int k = 0; k < 10; k++) begin
         n_cmp++; if (got_data[k] !== 32'(k) || got_last[k] !== (k == 9)) begin
            n_bad++; $display("FAIL rstmid_word%0d got %h last=%b want %h last=%b", k, got_data[k], got_last[k], k, (k == 9)); end
      end
   endtask

   task automatic test_strobe_rules();
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL strobe_rules got %0d violations want 0", viol); end
   endtask

   initial begin
      #1;
      test_reset();
      test_load_read();
      test_f(1'b0);
      test_stall_g();
      test_f(1'b1);
      test_reset_mid();
      test_strobe_rules();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog got no completion want summary");
      $fatal(1);
   end

endmodule
